// File: rtl/frame_timing_check.sv
// Frame timing checker: measures line width, frame height and pixel XOR
// checksum of each frame and flags width and lval/fval framing errors.
module frame_timing_check #(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CHANNEL_NUM      = 4,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_fval,
    input  logic                                  i_lval,
    input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    output logic                                  o_info_valid,
    output logic [CNT_WIDTH-1:0]                  ov_line_width,
    output logic [CNT_WIDTH-1:0]                  ov_frame_height,
    output logic [CNT_WIDTH-1:0]                  ov_frame_cnt,
    output logic [SENSOR_DAT_WIDTH-1:0]           ov_checksum,
    output logic                                  o_width_err,
    output logic                                  o_lval_err
);

    localparam int PW = CNT_WIDTH + $clog2(CHANNEL_NUM) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    logic [1:0]                  state;
    logic                        fval_dly;
    logic                        lval_dly;
    logic [CNT_WIDTH-1:0]        clk_cnt;
    logic [CNT_WIDTH-1:0]        line_cnt;
    logic [CNT_WIDTH-1:0]        first_width;
    logic [SENSOR_DAT_WIDTH-1:0] csum;
    logic                        werr;
    logic                        lval_err;

    logic                        frame_start;
    logic                        frame_end;
    logic                        line_end;
    logic                        pix_en;
    logic                        lval_bad;
    logic                        take;
    logic [SENSOR_DAT_WIDTH-1:0] pix_xor;
    logic [PW-1:0]               prod;
    logic [CNT_WIDTH-1:0]        line_width;

    logic [CNT_WIDTH-1:0]        clk_cnt_nxt;
    logic [CNT_WIDTH-1:0]        line_cnt_nxt;
    logic [CNT_WIDTH-1:0]        first_width_nxt;
    logic [SENSOR_DAT_WIDTH-1:0] csum_nxt;
    logic                        werr_nxt;

    assign frame_start = ~fval_dly & i_fval;
    assign frame_end   = fval_dly & ~i_fval;
    assign line_end    = lval_dly & (~i_lval | ~i_fval);
    assign pix_en      = i_fval & i_lval;
    assign lval_bad    = i_lval & ~i_fval;
    assign take        = (state == ACTIVE) & frame_end;

    always_comb begin
        pix_xor = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            pix_xor = pix_xor ^ iv_pix_data[k*SENSOR_DAT_WIDTH +: SENSOR_DAT_WIDTH];
        end
    end

    always_comb begin
        prod = PW'(clk_cnt) * PW'(CHANNEL_NUM);
        if (prod > PW'(CNT_MAX)) begin
            line_width = CNT_MAX;
        end else begin
            line_width = prod[CNT_WIDTH-1:0];
        end
    end

    // Next accumulator values; the report samples these so a line ending
    // together with the frame is already counted.
    always_comb begin
        clk_cnt_nxt     = clk_cnt;
        line_cnt_nxt    = line_cnt;
        first_width_nxt = first_width;
        csum_nxt        = csum;
        werr_nxt        = werr;
        if (pix_en) begin
            if (clk_cnt != CNT_MAX) begin
                clk_cnt_nxt = clk_cnt + 1'b1;
            end
            csum_nxt = csum ^ pix_xor;
        end
        if (line_end) begin
            clk_cnt_nxt = '0;
            if (line_cnt != CNT_MAX) begin
                line_cnt_nxt = line_cnt + 1'b1;
            end
            if (line_cnt == '0) begin
                first_width_nxt = line_width;
            end else if (line_width != first_width) begin
                werr_nxt = 1'b1;
            end
        end
    end

    // fval_dly resets high so a frame already running at release is not
    // mistaken for a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fval_dly <= 1'b1;
            lval_dly <= 1'b0;
        end else begin
            fval_dly <= i_fval;
            lval_dly <= i_fval & i_lval;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (frame_start) state <= ACTIVE;
                ACTIVE:  if (frame_end) state <= REPORT;
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt     <= '0;
            line_cnt    <= '0;
            first_width <= '0;
            csum        <= '0;
            werr        <= 1'b0;
        end else if (state == IDLE && frame_start) begin
            clk_cnt     <= '0;
            line_cnt    <= '0;
            first_width <= '0;
            csum        <= '0;
            werr        <= 1'b0;
        end else if (state == ACTIVE) begin
            clk_cnt     <= clk_cnt_nxt;
            line_cnt    <= line_cnt_nxt;
            first_width <= first_width_nxt;
            csum        <= csum_nxt;
            werr        <= werr_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lval_err <= 1'b0;
        end else if (take) begin
            lval_err <= 1'b0;
        end else if (lval_bad) begin
            lval_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_info_valid    <= 1'b0;
            ov_line_width   <= '0;
            ov_frame_height <= '0;
            ov_frame_cnt    <= '0;
            ov_checksum     <= '0;
            o_width_err     <= 1'b0;
            o_lval_err      <= 1'b0;
        end else begin
            o_info_valid <= take;
            if (take) begin
                ov_line_width   <= first_width_nxt;
                ov_frame_height <= line_cnt_nxt;
                ov_frame_cnt    <= ov_frame_cnt + 1'b1;
                ov_checksum     <= csum_nxt;
                o_width_err     <= werr_nxt;
                o_lval_err      <= lval_err | lval_bad;
            end
        end
    end

endmodule
